// File: rtl/prefetch_pkg.sv
// Shared types and grid geometry helpers for the prefetch scheduler and the 3D prefetch engine.
// Latency: combinational functions only.
// Backpressure: n/a.
// Contents: state_t (scheduler FSM), in_bounds() (the engine's bounds check), nbr_count().
package prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COLLECT = 2'd2,
    GUARD   = 2'd3
  } state_t;

  // Linear address is inside the xs*ys*zs grid.
  function automatic logic in_bounds(input logic [31:0] addr,
                                     input int unsigned xs,
                                     input int unsigned ys,
                                     input int unsigned zs);
    return addr < 32'(xs * ys * zs);
  endfunction

  // Number of face neighbours the engine returns for addr (0 when out of bounds).
  // Coordinates use the same div/mod decomposition as the engine: x fastest, then y, then z.
  function automatic logic [2:0] nbr_count(input logic [31:0] addr,
                                           input int unsigned xs,
                                           input int unsigned ys,
                                           input int unsigned zs);
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [2:0]  n;
    n = 3'd0;
    x = addr % xs;
    y = (addr / xs) % ys;
    z = addr / (xs * ys);
    if (in_bounds(addr, xs, ys, zs)) begin
      if (x != 32'd0)   n = n + 3'd1;
      if (x + 1 < xs)   n = n + 3'd1;
      if (y != 32'd0)   n = n + 3'd1;
      if (y + 1 < ys)   n = n + 3'd1;
      if (z != 32'd0)   n = n + 3'd1;
      if (z + 1 < zs)   n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or after the pointer.
// Latency: grant is combinational; pointer moves on the clock after an accepted grant.
// Backpressure: pointer holds until advance is asserted with a valid grant.
// Ports: clock, reset (sync, active-high), req[N], advance -> grant[N], grant_idx, grant_vld.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [IW-1:0] ptr;

  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!grant_vld && req[j]) begin
        grant_vld = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && grant_vld) begin
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/prefetch_scheduler.sv
// Shares one 3D neighbour prefetch engine among NUM_REQ requesters; routes each result to its owner.
// Latency: grant+issue 2 cycles, then one registered response per engine result, then GUARD_CYCLES settle.
// Backpressure: requesters hold req_valid until the req_ready pulse; nothing is granted outside IDLE.
// Ports: req_valid/req_addr/req_ready (requesters), pf_valid/pf_addr/pf_ready/pf_addr_o (engine),
//        rsp_valid/rsp_id/rsp_addr/rsp_oob (results), busy, timeout_err (sticky), drop_count (saturating).
module prefetch_scheduler
  import prefetch_pkg::*;
#(
  parameter int xSize        = 3,
  parameter int ySize        = 3,
  parameter int zSize        = 3,
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT      = 16,
  parameter int GUARD_CYCLES = 2,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  pf_valid,
  output logic [31:0]           pf_addr,
  input  logic                  pf_ready,
  input  logic [31:0]           pf_addr_o,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           rsp_addr,
  output logic                  rsp_oob,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [15:0]           drop_count
);

  localparam int WDW = $clog2(TIMEOUT) + 1;
  localparam int GW  = $clog2(GUARD_CYCLES) + 1;

  state_t        state;
  logic [31:0]   addr_q;
  logic [31:0]   last_addr;
  logic          last_addr_vld;
  logic [IDW-1:0] id_q;
  logic          oob_q;
  logic [2:0]    expected;
  logic [2:0]    cnt;
  logic [WDW-1:0] wd;
  logic [GW-1:0] gcnt;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               grant_vld;
  logic [31:0]        gaddr;
  logic               g_inb;

  // While a req_ready pulse is on the wire the requester has not yet dropped
  // its valid; masking that cycle stops a dropped hint from being granted twice.
  assign arb_req = (state == IDLE && req_ready == '0) ? req_valid : '0;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (arb_req),
    .advance   (grant_vld),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_comb begin
    gaddr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gaddr = req_addr[32*i +: 32];
    end
  end

  assign g_inb = in_bounds(gaddr, xSize, ySize, zSize);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      req_ready     <= '0;
      pf_valid      <= 1'b0;
      pf_addr       <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_addr      <= '0;
      rsp_oob       <= 1'b0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      drop_count    <= '0;
      addr_q        <= '0;
      last_addr     <= '0;
      last_addr_vld <= 1'b0;
      id_q          <= '0;
      oob_q         <= 1'b0;
      expected      <= '0;
      cnt           <= '0;
      wd            <= '0;
      gcnt          <= '0;
    end else begin
      req_ready <= '0;
      pf_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_vld) begin
            req_ready <= grant;
            if (last_addr_vld && gaddr == last_addr) begin
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end else begin
              addr_q   <= gaddr;
              id_q     <= grant_idx;
              oob_q    <= !g_inb;
              // The engine acks an out-of-bounds address with a single result.
              expected <= g_inb ? nbr_count(gaddr, xSize, ySize, zSize) : 3'd1;
              pf_valid <= 1'b1;
              pf_addr  <= gaddr;
              busy     <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          wd    <= '0;
          state <= COLLECT;
        end
        COLLECT: begin
          if (pf_ready) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_addr  <= pf_addr_o;
            rsp_oob   <= oob_q;
            cnt       <= cnt + 3'd1;
            wd        <= '0;
            if (cnt + 3'd1 == expected) begin
              // Only a fully served in-bounds hint may suppress a repeat.
              last_addr_vld <= !oob_q;
              if (!oob_q) last_addr <= addr_q;
              gcnt  <= '0;
              state <= GUARD;
            end
          end else if (wd == WDW'(TIMEOUT - 1)) begin
            timeout_err   <= 1'b1;
            last_addr_vld <= 1'b0;
            gcnt          <= '0;
            state         <= GUARD;
          end else begin
            wd <= wd + WDW'(1);
          end
        end
        GUARD: begin
          if (gcnt == GW'(GUARD_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prefetch_scheduler.sv
// Directed bench for prefetch_scheduler on a 3x3x3 grid; the bench plays the prefetch engine.
// Latency: n/a.
// Backpressure: requesters hold valid until req_ready, as the design expects.
module tb_prefetch_scheduler;

  logic         clock;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_addr;
  logic [3:0]   req_ready;
  logic         pf_valid;
  logic [31:0]  pf_addr;
  logic         pf_ready;
  logic [31:0]  pf_addr_o;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_addr;
  logic         rsp_oob;
  logic         busy;
  logic         timeout_err;
  logic [15:0]  drop_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0]      addr;
    int               n;
    logic [5:0][31:0] nb;
    logic             oob;
  } vec_t;

  vec_t vecs[4];

  prefetch_scheduler #(
    .xSize(3), .ySize(3), .zSize(3), .NUM_REQ(4), .TIMEOUT(16), .GUARD_CYCLES(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .pf_valid    (pf_valid),
    .pf_addr     (pf_addr),
    .pf_ready    (pf_ready),
    .pf_addr_o   (pf_addr_o),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_addr    (rsp_addr),
    .rsp_oob     (rsp_oob),
    .busy        (busy),
    .timeout_err (timeout_err),
    .drop_count  (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input int r, input logic [31:0] a);
    req_addr[32*r +: 32] = a;
    req_valid[r]         = 1'b1;
  endtask

  task automatic wait_grant(input string name, input logic [3:0] exp_g);
    int k;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (req_ready == 4'b0 && k < 40);
    check({name, "_grant"}, 64'(req_ready), 64'(exp_g));
    req_valid = req_valid & ~req_ready;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 8) begin
      @(negedge clock);
      k++;
    end
    check({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_issue(input string name, input logic [31:0] a);
    check({name, "_issue"}, 64'({pf_valid, pf_addr}), 64'({1'b1, a}));
  endtask

  // Engine side: wait out the engine latency, then one pf_ready per result.
  task automatic serve(input string name, input vec_t v, input logic [1:0] id);
    @(negedge clock);
    check({name, "_pf_one_cycle"}, 64'(pf_valid), 64'd0);
    @(negedge clock);
    for (int k = 0; k < v.n; k++) begin
      pf_ready  = 1'b1;
      pf_addr_o = v.nb[k];
      @(negedge clock);
      check({name, "_rsp"}, 64'({rsp_valid, rsp_oob, rsp_id, rsp_addr}),
            64'({1'b1, v.oob, id, v.nb[k]}));
    end
    pf_ready  = 1'b0;
    pf_addr_o = '0;
    @(negedge clock);
    check({name, "_no_extra_rsp"}, 64'(rsp_valid), 64'd0);
    wait_idle(name);
  endtask

  task automatic txn(input string name, input int r, input vec_t v);
    send(r, v.addr);
    wait_grant(name, 4'(1 << r));
    check_issue(name, v.addr);
    serve(name, v, 2'(r));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].addr = 32'd13; vecs[0].n = 6; vecs[0].oob = 1'b0;
    vecs[0].nb   = {32'd22, 32'd4, 32'd16, 32'd10, 32'd14, 32'd12};
    vecs[1].addr = 32'd0;  vecs[1].n = 3; vecs[1].oob = 1'b0;
    vecs[1].nb   = {32'd0, 32'd0, 32'd0, 32'd9, 32'd3, 32'd1};
    vecs[2].addr = 32'd26; vecs[2].n = 3; vecs[2].oob = 1'b0;
    vecs[2].nb   = {32'd0, 32'd0, 32'd0, 32'd17, 32'd23, 32'd25};
    vecs[3].addr = 32'd27; vecs[3].n = 1; vecs[3].oob = 1'b1;
    vecs[3].nb   = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};

    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    pf_ready  = 1'b0;
    pf_addr_o = '0;
    tick(3);
    check("reset_ctl", 64'({req_ready, pf_valid, rsp_valid, rsp_oob, busy, timeout_err, rsp_id}), 64'd0);
    check("reset_data", 64'({pf_addr, rsp_addr}), 64'd0);
    check("reset_drop", 64'(drop_count), 64'd0);
    reset = 1'b0;
    tick(1);

    // Centre, corners and out-of-bounds from requester 0.
    for (int i = 0; i < 4; i++) begin
      txn($sformatf("vec%0d", i), 0, vecs[i]);
    end

    // Repeated in-bounds hint is acked but not issued.
    txn("dup_first", 1, vecs[0]);
    send(1, 32'd13);
    wait_grant("dup_second", 4'b0010);
    check("dup_no_issue", 64'({pf_valid, busy}), 64'd0);
    check("dup_count", 64'(drop_count), 64'd1);
    tick(1);
    check("dup_still_idle", 64'({pf_valid, busy, req_ready}), 64'd0);

    // Out-of-bounds hints never suppress a repeat.
    txn("oob_first", 1, vecs[3]);
    txn("oob_second", 1, vecs[3]);
    check("oob_drop_unchanged", 64'(drop_count), 64'd1);

    // Round robin from a fresh pointer.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    send(0, 32'd0);
    send(2, 32'd26);
    wait_grant("rr_first", 4'b0001);
    check_issue("rr_first", 32'd0);
    serve("rr_first", vecs[1], 2'd0);
    send(0, 32'd13);
    wait_grant("rr_second", 4'b0100);
    check_issue("rr_second", 32'd26);
    serve("rr_second", vecs[2], 2'd2);
    wait_grant("rr_third", 4'b0001);
    check_issue("rr_third", 32'd13);
    serve("rr_third", vecs[0], 2'd0);

    // Engine never answers: abort after TIMEOUT idle collect cycles.
    send(0, 32'd14);
    wait_grant("to", 4'b0001);
    tick(16);
    check("to_not_yet", 64'(timeout_err), 64'd0);
    tick(1);
    check("to_fired", 64'({timeout_err, busy}), 64'b11);
    pf_ready  = 1'b1;
    pf_addr_o = 32'd5;
    tick(1);
    check("guard_ignores_pf_ready", 64'(rsp_valid), 64'd0);
    pf_ready  = 1'b0;
    pf_addr_o = '0;
    wait_idle("to");
    check("to_sticky", 64'(timeout_err), 64'd1);

    // Reset in COLLECT with a result arriving on the same edge.
    send(3, 32'd0);
    wait_grant("rst", 4'b1000);
    tick(2);
    pf_ready  = 1'b1;
    pf_addr_o = 32'd1;
    reset     = 1'b1;
    tick(1);
    check("rst_ctl", 64'({req_ready, pf_valid, rsp_valid, rsp_oob, busy, timeout_err, rsp_id}), 64'd0);
    check("rst_data", 64'({pf_addr, rsp_addr}), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    reset     = 1'b0;
    pf_ready  = 1'b0;
    pf_addr_o = '0;
    tick(2);
    check("rst_quiet", 64'({rsp_valid, busy, pf_valid}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
